// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Optional feature macro used by the top: DMEM_ARBITER_PERF_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ISSUED = 2'd1,
    ARB_WAIT   = 2'd2
  } arb_state_t;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  // True when the memory needs its extra cycle for this size/alignment.
  function automatic logic is_unaligned(input logic [2:0] mode, input logic [1:0] addr_lo);
    logic v;
    v = 1'b0;
    case (mode[1:0])
      MEM_HALF: v = (addr_lo == 2'd3);
      MEM_WORD: v = (addr_lo != 2'd0);
      default:  v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dmem_arb_prio.sv
// Winner selection and starvation counter for the data-memory arbiter.
// m0 has priority; after STARVE_LIMIT consecutive m0 grants with m1 waiting,
// the next grant goes to m1.
module dmem_arb_prio
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_m0_req,
  input  logic i_m1_req,
  input  logic i_issue_ok,
  output logic o_sel_m1,
  output logic o_grant_valid
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] r_scnt;

  // Pick the winner and decide whether a grant happens this cycle.
  always_comb begin
    o_grant_valid = i_issue_ok & (i_m0_req | i_m1_req);
    o_sel_m1      = i_m1_req & (~i_m0_req | (r_scnt == LIMIT));
  end

  // Count m0 grants made while m1 is kept waiting; saturate at the limit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_scnt <= 8'd0;
    end else if (!i_m1_req) begin
      r_scnt <= 8'd0;
    end else if (o_grant_valid && o_sel_m1) begin
      r_scnt <= 8'd0;
    end else if (o_grant_valid && (r_scnt != LIMIT)) begin
      r_scnt <= r_scnt + 8'd1;
    end else begin
      r_scnt <= r_scnt;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the memory data port.
// Optional macro DMEM_ARBITER_PERF_EN adds grant and wait-cycle counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT   = 8,
  parameter int M1_ALLOW_WRITE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_mode,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_mode,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_address,
  output logic        mem_enable,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_read_mode,
  output logic [2:0]  mem_write_mode,
  input  logic [31:0] mem_read_data,
  input  logic        mem_wait
`ifdef DMEM_ARBITER_PERF_EN
  ,
  output logic [31:0] perf_m0_grants,
  output logic [31:0] perf_m1_grants,
  output logic [31:0] perf_wait_cycles
`endif
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_owner;
  logic       r_err_pend;
  logic       r_ready;
  logic       w_issue_ok;
  logic       w_sel_m1;
  logic       w_grant_valid;
  logic       w_complete;
  logic       w_squash;
  logic       w_eff_we;

  // A new access may start when idle or when the outstanding one finishes now.
  // r_ready keeps everything quiet for the first cycle after reset.
  always_comb begin
    if (!reset_n || !r_ready) begin
      w_issue_ok = 1'b0;
    end else if (r_state == ARB_IDLE) begin
      w_issue_ok = 1'b1;
    end else begin
      w_issue_ok = ~mem_wait;
    end
  end

  dmem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_m0_req      (m0_req),
    .i_m1_req      (m1_req),
    .i_issue_ok    (w_issue_ok),
    .o_sel_m1      (w_sel_m1),
    .o_grant_valid (w_grant_valid)
  );

  // Next-state logic and completion detection.
  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_state_nxt = ARB_IDLE;
      end
      ARB_ISSUED, ARB_WAIT: begin
        if (mem_wait) begin
          w_state_nxt = ARB_WAIT;
        end else begin
          w_complete  = reset_n;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
    if (w_grant_valid) begin
      w_state_nxt = ARB_ISSUED;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // Drive the memory port from the winner and route completion to the owner.
  always_comb begin
    m0_gnt           = 1'b0;
    m1_gnt           = 1'b0;
    mem_enable       = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = 32'd0;
    mem_write_data   = 32'd0;
    mem_read_mode    = 3'd0;
    mem_write_mode   = 3'd0;
    // m1 writes become reads when m1 is not trusted to write.
    w_squash = w_sel_m1 & m1_we & (M1_ALLOW_WRITE == 0);
    w_eff_we = (w_sel_m1 ? m1_we : m0_we) & ~w_squash;
    if (w_grant_valid) begin
      m0_gnt           = ~w_sel_m1;
      m1_gnt           = w_sel_m1;
      mem_enable       = 1'b1;
      mem_write_enable = w_eff_we;
      mem_read_enable  = ~w_eff_we;
      mem_address      = w_sel_m1 ? m1_addr  : m0_addr;
      mem_write_data   = w_sel_m1 ? m1_wdata : m0_wdata;
      mem_read_mode    = w_sel_m1 ? m1_mode  : m0_mode;
      mem_write_mode   = w_sel_m1 ? m1_mode  : m0_mode;
    end else begin
      m0_gnt = 1'b0;
    end
    m0_done  = w_complete & ~r_owner;
    m1_done  = w_complete & r_owner;
    m0_rdata = m0_done ? mem_read_data : 32'd0;
    m1_rdata = m1_done ? mem_read_data : 32'd0;
    m1_err   = m1_done & r_err_pend;
  end

  // State, owner and squash flag registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ARB_IDLE;
      r_owner    <= 1'b0;
      r_err_pend <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= 1'b1;
      if (w_grant_valid) begin
        r_owner    <= w_sel_m1;
        r_err_pend <= w_squash;
      end else begin
        r_owner    <= r_owner;
        r_err_pend <= r_err_pend;
      end
    end
  end

`ifdef DMEM_ARBITER_PERF_EN
  logic [31:0] r_perf_m0;
  logic [31:0] r_perf_m1;
  logic [31:0] r_perf_wait;

  // Free-running, wrapping grant and wait-cycle counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perf_m0   <= 32'd0;
      r_perf_m1   <= 32'd0;
      r_perf_wait <= 32'd0;
    end else begin
      r_perf_m0   <= r_perf_m0 + {31'd0, m0_gnt};
      r_perf_m1   <= r_perf_m1 + {31'd0, m1_gnt};
      r_perf_wait <= r_perf_wait + {31'd0, (r_state == ARB_WAIT)};
    end
  end

  assign perf_m0_grants   = r_perf_m0;
  assign perf_m1_grants   = r_perf_m1;
  assign perf_wait_cycles = r_perf_wait;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (STARVE_LIMIT=8, M1_ALLOW_WRITE=0).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_mode, m1_mode;
  logic        m0_gnt, m1_gnt, m0_done, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_enable, mem_read_enable, mem_write_enable, mem_wait;
  logic [2:0]  mem_read_mode, mem_write_mode;
`ifdef DMEM_ARBITER_PERF_EN
  logic [31:0] perf_m0_grants, perf_m1_grants, perf_wait_cycles;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(8), .M1_ALLOW_WRITE(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mode(m0_mode),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mode(m1_mode),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_address(mem_address), .mem_enable(mem_enable), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_read_mode(mem_read_mode), .mem_write_mode(mem_write_mode),
    .mem_read_data(mem_read_data), .mem_wait(mem_wait)
`ifdef DMEM_ARBITER_PERF_EN
    , .perf_m0_grants(perf_m0_grants), .perf_m1_grants(perf_m1_grants),
    .perf_wait_cycles(perf_wait_cycles)
`endif
  );

  // Advance to just after the next rising edge; inputs are then driven for that cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    m0_req = 1'b1; m0_addr = 32'h8000_0000; m0_mode = 3'd2;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, mem_enable, m0_done, m1_done, m1_err} !== 6'b0) begin
      errors++; $display("FAIL reset_cycle_outputs: got %b expected 000000", {m0_gnt, m1_gnt, mem_enable, m0_done, m1_done, m1_err});
    end
    step();
    reset_n = 1'b1;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, mem_enable, mem_read_enable, m0_done} !== 5'b0) begin
      errors++; $display("FAIL post_reset_quiet: got %b expected 00000", {m0_gnt, m1_gnt, mem_enable, mem_read_enable, m0_done});
    end
    m0_req = 1'b0;
    step();
    #1;
`ifdef DMEM_ARBITER_PERF_EN
    checks++;
    if ({perf_m0_grants, perf_m1_grants, perf_wait_cycles} !== 96'd0) begin
      errors++; $display("FAIL perf_reset: got %h expected 0", {perf_m0_grants, perf_m1_grants, perf_wait_cycles});
    end
`endif
  endtask

  task automatic test_read_aligned();
    step();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8000_0010; m0_mode = 3'd2;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, mem_enable, mem_read_enable, mem_write_enable} !== 5'b10110) begin
      errors++; $display("FAIL aligned_issue: got %b expected 10110", {m0_gnt, m1_gnt, mem_enable, mem_read_enable, mem_write_enable});
    end
    checks++;
    if ({mem_address, mem_read_mode} !== {32'h8000_0010, 3'd2}) begin
      errors++; $display("FAIL aligned_addr_mode: got %h/%0d expected 80000010/2", mem_address, mem_read_mode);
    end
    step();
    m0_req = 1'b0; mem_read_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({m0_done, m1_done, m0_gnt} !== 3'b100) begin
      errors++; $display("FAIL aligned_done: got %b expected 100", {m0_done, m1_done, m0_gnt});
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== {32'hDEAD_BEEF, 32'h0}) begin
      errors++; $display("FAIL aligned_rdata: got %h/%h expected deadbeef/0", m0_rdata, m1_rdata);
    end
    step();
    #1;
    checks++;
    if ({m0_done, m0_rdata} !== 33'd0) begin
      errors++; $display("FAIL rdata_gated: got %b/%h expected 0/0", m0_done, m0_rdata);
    end
  endtask

  task automatic test_write();
    step();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h8000_0020; m0_wdata = 32'h1122_3344; m0_mode = 3'd2;
    #1;
    checks++;
    if ({m0_gnt, mem_enable, mem_read_enable, mem_write_enable, mem_write_data, mem_write_mode} !== {4'b1101, 32'h1122_3344, 3'd2}) begin
      errors++; $display("FAIL m0_write_issue: got %b%b%b%b %h %0d expected 1101 11223344 2", m0_gnt, mem_enable, mem_read_enable, mem_write_enable, mem_write_data, mem_write_mode);
    end
    step();
    m0_req = 1'b0; m0_we = 1'b0;
    #1;
    checks++;
    if ({m0_done, m1_done} !== 2'b10) begin
      errors++; $display("FAIL m0_write_done: got %b expected 10", {m0_done, m1_done});
    end
  endtask

  task automatic test_unaligned();
    step();
    m0_req = 1'b1; m0_addr = 32'h8000_0011; m0_mode = 3'd2;
    #1;
    checks++;
    if (m0_gnt !== 1'b1) begin
      errors++; $display("FAIL unaligned_gnt: got %b expected 1", m0_gnt);
    end
    step();
    m0_req = 1'b0; mem_wait = 1'b1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8000_0040; m1_mode = 3'd2;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, m0_done, m1_done, mem_enable} !== 5'b0) begin
      errors++; $display("FAIL unaligned_wait_cycle: got %b expected 00000", {m0_gnt, m1_gnt, m0_done, m1_done, mem_enable});
    end
    step();
    mem_wait = 1'b0; mem_read_data = 32'h1234_5678;
    #1;
    checks++;
    if ({m0_done, m1_gnt, m0_rdata} !== {2'b11, 32'h1234_5678}) begin
      errors++; $display("FAIL unaligned_done: got %b%b %h expected 11 12345678", m0_done, m1_gnt, m0_rdata);
    end
    checks++;
    if (mem_address !== 32'h8000_0040) begin
      errors++; $display("FAIL m1_issue_addr: got %h expected 80000040", mem_address);
    end
    step();
    m1_req = 1'b0; mem_read_data = 32'hCAFE_F00D;
    #1;
    checks++;
    if ({m1_done, m1_err, m0_done, m1_rdata} !== {3'b100, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL m1_read_done: got %b%b%b %h expected 100 cafef00d", m1_done, m1_err, m0_done, m1_rdata);
    end
  endtask

  task automatic test_starve();
    logic exp_m1;
    logic prev_m1;
    prev_m1 = 1'b0;
    m0_addr = 32'h8000_0000; m0_mode = 3'd2; m0_we = 1'b0;
    m1_addr = 32'h8000_0100; m1_mode = 3'd2; m1_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      m0_req = 1'b1; m1_req = 1'b1;
      #1;
      exp_m1 = ((i % 9) == 8);
      checks++;
      if ({m0_gnt, m1_gnt} !== {~exp_m1, exp_m1}) begin
        errors++; $display("FAIL starve_gnt[%0d]: got %b%b expected %b%b", i, m0_gnt, m1_gnt, ~exp_m1, exp_m1);
      end
      if (i > 0) begin
        checks++;
        if ({m0_done, m1_done} !== {~prev_m1, prev_m1}) begin
          errors++; $display("FAIL starve_done[%0d]: got %b%b expected %b%b", i, m0_done, m1_done, ~prev_m1, prev_m1);
        end
      end
      prev_m1 = exp_m1;
    end
    step();
    m0_req = 1'b0; m1_req = 1'b0;
    #1;
    checks++;
    if ({m0_done, m1_done, m0_gnt, m1_gnt} !== 4'b1000) begin
      errors++; $display("FAIL starve_drain: got %b expected 1000", {m0_done, m1_done, m0_gnt, m1_gnt});
    end
  endtask

  task automatic test_squash();
    step();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h7000_0000; m1_wdata = 32'hA5A5_A5A5; m1_mode = 3'd2;
    #1;
    checks++;
    if ({m1_gnt, m0_gnt, mem_enable, mem_read_enable, mem_write_enable} !== 5'b10110) begin
      errors++; $display("FAIL squash_issue: got %b expected 10110", {m1_gnt, m0_gnt, mem_enable, mem_read_enable, mem_write_enable});
    end
    checks++;
    if ({mem_address, mem_write_data} !== {32'h7000_0000, 32'hA5A5_A5A5}) begin
      errors++; $display("FAIL squash_fields: got %h %h expected 70000000 a5a5a5a5", mem_address, mem_write_data);
    end
    step();
    m1_req = 1'b0; m1_we = 1'b0;
    #1;
    checks++;
    if ({m1_done, m1_err, m0_done} !== 3'b110) begin
      errors++; $display("FAIL squash_done_err: got %b expected 110", {m1_done, m1_err, m0_done});
    end
    step();
    #1;
    checks++;
    if ({m1_done, m1_err} !== 2'b00) begin
      errors++; $display("FAIL squash_err_pulse: got %b expected 00", {m1_done, m1_err});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [3];
    data[0] = 32'h0101_0101; data[1] = 32'h0202_0202; data[2] = 32'h0303_0303;
    for (int i = 0; i < 3; i++) begin
      step();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'(i * 4); m0_mode = 3'd2;
      mem_read_data = (i > 0) ? data[i-1] : 32'h0;
      #1;
      checks++;
      if ({m0_gnt, mem_address} !== {1'b1, 32'(i * 4)}) begin
        errors++; $display("FAIL b2b_gnt[%0d]: got %b %h expected 1 %h", i, m0_gnt, mem_address, 32'(i * 4));
      end
      if (i > 0) begin
        checks++;
        if ({m0_done, m0_rdata} !== {1'b1, data[i-1]}) begin
          errors++; $display("FAIL b2b_done[%0d]: got %b %h expected 1 %h", i, m0_done, m0_rdata, data[i-1]);
        end
      end
    end
    step();
    m0_req = 1'b0; mem_read_data = data[2];
    #1;
    checks++;
    if ({m0_done, m0_rdata, m0_gnt} !== {1'b1, data[2], 1'b0}) begin
      errors++; $display("FAIL b2b_last_done: got %b %h %b expected 1 %h 0", m0_done, m0_rdata, m0_gnt, data[2]);
    end
    step();
    #1;
    checks++;
    if (m0_done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got %b expected 0", m0_done);
    end
  endtask

  task automatic test_reset_mid();
    step();
    m0_req = 1'b1; m0_addr = 32'h8000_0002; m0_mode = 3'd2;
    #1;
    checks++;
    if (m0_gnt !== 1'b1) begin
      errors++; $display("FAIL midrst_gnt: got %b expected 1", m0_gnt);
    end
    step();
    m0_req = 1'b0; reset_n = 1'b0; mem_wait = 1'b1;
    #1;
    checks++;
    if ({m0_done, m1_done, m0_gnt, mem_enable, mem_read_enable, mem_write_enable, mem_address} !== 38'd0) begin
      errors++; $display("FAIL midrst_reset_cycle: got %b %h expected 0", {m0_done, m1_done, m0_gnt, mem_enable, mem_read_enable, mem_write_enable}, mem_address);
    end
    step();
    reset_n = 1'b1; mem_wait = 1'b0;
    #1;
    checks++;
    if ({m0_done, mem_enable, mem_read_enable, mem_write_enable, mem_address} !== 36'd0) begin
      errors++; $display("FAIL midrst_after: got %b %h expected 0", {m0_done, mem_enable, mem_read_enable, mem_write_enable}, mem_address);
    end
`ifdef DMEM_ARBITER_PERF_EN
    checks++;
    if ({perf_m0_grants, perf_m1_grants, perf_wait_cycles} !== 96'd0) begin
      errors++; $display("FAIL midrst_perf: got %h expected 0", {perf_m0_grants, perf_m1_grants, perf_wait_cycles});
    end
`endif
    step();
    #1;
    checks++;
    if (m0_done !== 1'b0) begin
      errors++; $display("FAIL midrst_no_done: got %b expected 0", m0_done);
    end
  endtask

  initial begin
    reset_n = 1'b0; mem_wait = 1'b0; mem_read_data = 32'h0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_mode = 3'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_mode = 3'd0;
    test_reset();
    test_read_aligned();
    test_write();
    test_unaligned();
    test_starve();
    test_squash();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence above never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
